// File: rtl/button_event_reader.sv
// Push-button reader: 2-flop synchroniser, debounce FSM, press/release event latching
// and a read-to-clear status word. Optional interrupt output enabled by BUTTON_IRQ_EN.
module button_event_reader #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button_in,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        btn_level,
    output logic        press_pulse,
    output logic        irq
);

    localparam logic             IDLE_PAD = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sync1;
    logic             sync2;
    logic             s;
    logic             accept;
    logic             press_evt;
    logic             rel_evt;
    logic             press_sticky;
    logic             rel_sticky;
    logic [7:0]       press_cnt;

    // Sync flops reset to the idle pad level so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= IDLE_PAD;
            sync2 <= IDLE_PAD;
        end else begin
            sync1 <= button_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2 ^ IDLE_PAD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STABLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            STABLE: begin
                if (s != btn_level) begin
                    state_next = COUNTING;
                    cnt_next   = '0;
                end
            end
            COUNTING: begin
                if (s == btn_level) begin
                    state_next = STABLE;
                end else if (cnt == CNT_MAX) begin
                    accept     = 1'b1;
                    state_next = STABLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = STABLE;
        endcase
    end

    assign press_evt = accept & s;
    assign rel_evt   = accept & ~s;

    // A new event on the same edge as a read wins, so no event is ever dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level    <= 1'b0;
            press_pulse  <= 1'b0;
            press_sticky <= 1'b0;
            rel_sticky   <= 1'b0;
            press_cnt    <= 8'd0;
        end else begin
            press_pulse <= press_evt;
            if (accept) begin
                btn_level <= s;
            end
            if (press_evt) begin
                press_sticky <= 1'b1;
                press_cnt    <= press_cnt + 8'd1;
            end else if (rd_en) begin
                press_sticky <= 1'b0;
            end
            if (rel_evt) begin
                rel_sticky <= 1'b1;
            end else if (rd_en) begin
                rel_sticky <= 1'b0;
            end
        end
    end

    assign rd_data = {16'b0, press_cnt, 5'b0, rel_sticky, press_sticky, btn_level};

`ifdef BUTTON_IRQ_EN
    logic irq_q;

    // Follows press_sticky cycle for cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else if (press_evt) begin
            irq_q <= 1'b1;
        end else if (rd_en) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_reader.sv
// Directed bench for button_event_reader with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
module tb_button_event_reader;

    logic        clk;
    logic        rst;
    logic        button_in;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        btn_level;
    logic        press_pulse;
    logic        irq;

    int checks   = 0;
    int failures = 0;

`ifdef BUTTON_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    button_event_reader #(
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (1),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button_in  (button_in),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .btn_level  (btn_level),
        .press_pulse(press_pulse),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        button_in = 1'b1;
        rd_en     = 1'b0;
        step(2);
        check_eq("reset_rd_data", rd_data, 32'h0);
        check_eq("reset_level", {31'b0, btn_level}, 32'h0);
        check_eq("reset_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;

        // Idle pad for 20 cycles: nothing happens.
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_eq("idle_pulse", {31'b0, press_pulse}, 32'h0);
        end
        check_eq("idle_rd_data", rd_data, 32'h0);

        // Clean press: pad low sampled at edge N, accepted at N+6.
        button_in = 1'b0;
        step(1);
        step(4);
        check_eq("press_n4_level", {31'b0, btn_level}, 32'h0);
        step(1);
        check_eq("press_n5_pulse", {31'b0, press_pulse}, 32'h0);
        check_eq("press_n5_level", {31'b0, btn_level}, 32'h0);
        step(1);
        check_eq("press_n6_level", {31'b0, btn_level}, 32'h1);
        check_eq("press_n6_pulse", {31'b0, press_pulse}, 32'h1);
        check_eq("press_rd_data", rd_data, 32'h0000_0103);
        check_eq("press_irq", {31'b0, irq}, {31'b0, IRQ_ON});
        step(1);
        check_eq("press_pulse_once", {31'b0, press_pulse}, 32'h0);

        // Release: rel_sticky joins press_sticky.
        button_in = 1'b1;
        step(7);
        check_eq("release_rd_data", rd_data, 32'h0000_0106);
        check_eq("release_pulse", {31'b0, press_pulse}, 32'h0);

        // Read returns pre-edge state, then clears; a second read sees cleared stickies.
        rd_en = 1'b1;
        check_eq("read1_data", rd_data, 32'h0000_0106);
        step(1);
        check_eq("read2_data", rd_data, 32'h0000_0100);
        step(1);
        rd_en = 1'b0;
        check_eq("read_after_b2b", rd_data, 32'h0000_0100);
        check_eq("read_irq_cleared", {31'b0, irq}, 32'h0);

        // Short glitch of 3 cycles is rejected.
        button_in = 1'b0;
        step(3);
        button_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_eq("glitch_pulse", {31'b0, press_pulse}, 32'h0);
        end
        check_eq("glitch_rd_data", rd_data, 32'h0000_0100);

        // Press then read-clear.
        button_in = 1'b0;
        step(7);
        check_eq("press2_rd_data", rd_data, 32'h0000_0203);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check_eq("press2_cleared", rd_data, 32'h0000_0201);

        // Release then read-clear.
        button_in = 1'b1;
        step(7);
        check_eq("rel2_rd_data", rd_data, 32'h0000_0204);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check_eq("rel2_cleared", rd_data, 32'h0000_0200);

        // Read strobe on the exact acceptance edge: the event wins.
        button_in = 1'b0;
        step(6);
        check_eq("collide_pre_level", {31'b0, btn_level}, 32'h0);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check_eq("collide_rd_data", rd_data, 32'h0000_0303);
        check_eq("collide_pulse", {31'b0, press_pulse}, 32'h1);
        check_eq("collide_irq", {31'b0, irq}, {31'b0, IRQ_ON});

        // 252 more presses bring the count to 255, one more wraps it to 0.
        for (int i = 0; i < 252; i++) begin
            button_in = 1'b1;
            step(7);
            button_in = 1'b0;
            step(7);
        end
        check_eq("cnt_255", {24'b0, rd_data[15:8]}, 32'd255);
        button_in = 1'b1;
        step(7);
        button_in = 1'b0;
        step(7);
        check_eq("cnt_wrap", {24'b0, rd_data[15:8]}, 32'd0);
        check_eq("wrap_rd_data", rd_data, 32'h0000_0007);

        // Async reset in the middle of a release count.
        button_in = 1'b1;
        step(3);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_rd_data", rd_data, 32'h0);
        check_eq("rst_mid_level", {31'b0, btn_level}, 32'h0);
        check_eq("rst_mid_irq", {31'b0, irq}, 32'h0);
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_eq("post_rst_pulse", {31'b0, press_pulse}, 32'h0);
        end
        check_eq("post_rst_rd_data", rd_data, 32'h0);

        // Pad change after reset is still recognised.
        button_in = 1'b0;
        step(7);
        check_eq("post_rst_press", rd_data, 32'h0000_0103);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
